// File: rtl/param_updown_counter.sv
// Parametrised up/down/step-down counter with load, registered wrap pulse (rco)
// and a combinational terminal-count lookahead (tc) for chaining stages.
module param_updown_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEP  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cin,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             tc
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_STEP = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  mode_t          mode;
  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] result;
  logic           wrap;

  assign mode  = mode_t'(modo);
  assign q_ext = {1'b0, Q};

  // One extra bit holds the carry (up) or borrow (down) that flags a wrap.
  always_comb begin
    result = q_ext;
    unique case (mode)
      MODE_UP:   result = q_ext + ONE_X;
      MODE_DOWN: result = q_ext - ONE_X;
      MODE_STEP: result = q_ext - STEP_X;
      MODE_LOAD: result = {1'b0, D};
    endcase
  end

  assign wrap = result[WIDTH];
  assign tc   = enable & cin & wrap & (mode != MODE_LOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Q   <= '0;
      rco <= 1'b0;
    end else if (!enable) begin
      rco <= 1'b0;
    end else if (mode == MODE_LOAD) begin
      Q   <= D;
      rco <= 1'b1;
    end else if (cin) begin
      Q   <= result[WIDTH-1:0];
      rco <= wrap;
    end else begin
      rco <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench for param_updown_counter: directed vector table, corner
// sequences, a two-stage cascade and randomized ops against an integer model.
module tb_param_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4, STEP=3 instance
  logic       rst4 = 1'b0, en4 = 1'b0, cin4 = 1'b0;
  logic [1:0] modo4 = 2'b00;
  logic [3:0] d4 = '0, q4;
  logic       rco4, tc4;

  // WIDTH=8, STEP=100 instance
  logic       rst8 = 1'b0, en8 = 1'b0, cin8 = 1'b0;
  logic [1:0] modo8 = 2'b00;
  logic [7:0] d8 = '0, q8;
  logic       rco8, tc8;

  // two chained WIDTH=4 stages
  logic       rstc = 1'b0, enc = 1'b0;
  logic [1:0] modoc = 2'b00;
  logic [3:0] dc = '0, lo_q, hi_q;
  logic       lo_rco, lo_tc, hi_rco, hi_tc;

  param_updown_counter #(.WIDTH(4), .STEP(3)) dut4 (
    .clk(clk), .reset(rst4), .enable(en4), .cin(cin4), .modo(modo4),
    .D(d4), .Q(q4), .rco(rco4), .tc(tc4));

  param_updown_counter #(.WIDTH(8), .STEP(100)) dut8 (
    .clk(clk), .reset(rst8), .enable(en8), .cin(cin8), .modo(modo8),
    .D(d8), .Q(q8), .rco(rco8), .tc(tc8));

  param_updown_counter #(.WIDTH(4), .STEP(3)) lo (
    .clk(clk), .reset(rstc), .enable(enc), .cin(1'b1), .modo(modoc),
    .D(dc), .Q(lo_q), .rco(lo_rco), .tc(lo_tc));

  param_updown_counter #(.WIDTH(4), .STEP(3)) hi (
    .clk(clk), .reset(rstc), .enable(enc), .cin(lo_tc), .modo(modoc),
    .D(dc), .Q(hi_q), .rco(hi_rco), .tc(hi_tc));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Integer model: next count and wrap flag from plain modular arithmetic.
  function automatic int model(input int w, input int step, input int q,
                               input logic [1:0] m, input bit en, input bit cin,
                               input int d, output bit rco, output bit tc);
    int span, n;
    span = 1 << w;
    rco = 1'b0;
    tc  = 1'b0;
    if (!en) return q;
    if (m == 2'b11) begin
      rco = 1'b1;
      return d;
    end
    if (!cin) return q;
    n = (m == 2'b00) ? q + 1 : (m == 2'b01) ? q - 1 : q - step;
    rco = (n < 0) || (n >= span);
    tc  = rco;
    return (n + span) % span;
  endfunction

  task automatic apply4(input logic [1:0] m, input bit en, input bit cin, input int d,
                        input int eq, input bit er, input bit et, input string tag);
    modo4 = m; en4 = en; cin4 = cin; d4 = d[3:0];
    #2 chk({tag, ".tc"}, int'(tc4), int'(et));
    @(posedge clk); #1;
    chk({tag, ".Q"}, int'(q4), eq);
    chk({tag, ".rco"}, int'(rco4), int'(er));
  endtask

  task automatic apply8(input logic [1:0] m, input bit en, input bit cin, input int d,
                        input int eq, input bit er, input bit et, input string tag);
    modo8 = m; en8 = en; cin8 = cin; d8 = d[7:0];
    #2 chk({tag, ".tc"}, int'(tc8), int'(et));
    @(posedge clk); #1;
    chk({tag, ".Q"}, int'(q8), eq);
    chk({tag, ".rco"}, int'(rco8), int'(er));
  endtask

  task automatic reset4();
    rst4 = 1'b1; en4 = 1'b0;
    #1 chk("reset.Q", int'(q4), 0);
    chk("reset.rco", int'(rco4), 0);
    @(negedge clk) rst4 = 1'b0;
    @(posedge clk); #1;
    chk("post_reset.Q", int'(q4), 0);
  endtask

  typedef struct {
    logic [1:0] m;
    bit         en;
    bit         cin;
    int         d;
    int         q;
    bit         rco;
    bit         tc;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int  m4, m8, eq, pulses, pulse_edge;
    bit  er, et, en, cin;
    logic [1:0] m;

    // up wrap: Q 1..15, 0, 1; tc while Q=15, rco after reaching 0
    for (int i = 1; i <= 17; i++)
      tbl.push_back('{2'b00, 1'b1, 1'b1, 0, i % 16, i == 16, i == 16});
    // load 2 then step down by 3 six times
    tbl.push_back('{2'b11, 1'b1, 1'b1, 2, 2, 1'b1, 1'b0});
    tbl.push_back('{2'b10, 1'b1, 1'b1, 0, 15, 1'b1, 1'b1});
    tbl.push_back('{2'b10, 1'b1, 1'b1, 0, 12, 1'b0, 1'b0});
    tbl.push_back('{2'b10, 1'b1, 1'b1, 0, 9, 1'b0, 1'b0});
    tbl.push_back('{2'b10, 1'b1, 1'b1, 0, 6, 1'b0, 1'b0});
    tbl.push_back('{2'b10, 1'b1, 1'b1, 0, 3, 1'b0, 1'b0});
    tbl.push_back('{2'b10, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0});
    tbl.push_back('{2'b11, 1'b1, 1'b1, 1, 1, 1'b1, 1'b0});
    tbl.push_back('{2'b10, 1'b1, 1'b1, 0, 14, 1'b1, 1'b1});
    tbl.push_back('{2'b11, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0});
    tbl.push_back('{2'b10, 1'b1, 1'b1, 0, 13, 1'b1, 1'b1});
    // holds: enable low, cin low; load still works with cin low
    tbl.push_back('{2'b11, 1'b1, 1'b1, 9, 9, 1'b1, 1'b0});
    tbl.push_back('{2'b00, 1'b0, 1'b1, 0, 9, 1'b0, 1'b0});
    tbl.push_back('{2'b00, 1'b0, 1'b1, 0, 9, 1'b0, 1'b0});
    tbl.push_back('{2'b00, 1'b0, 1'b1, 0, 9, 1'b0, 1'b0});
    tbl.push_back('{2'b01, 1'b1, 1'b0, 0, 9, 1'b0, 1'b0});
    tbl.push_back('{2'b11, 1'b1, 1'b0, 5, 5, 1'b1, 1'b0});

    #1 rst8 = 1'b1; rstc = 1'b1;
    reset4();
    rst8 = 1'b0; rstc = 1'b0;

    foreach (tbl[i])
      apply4(tbl[i].m, tbl[i].en, tbl[i].cin, tbl[i].d,
             tbl[i].q, tbl[i].rco, tbl[i].tc, $sformatf("vec%0d", i));

    // mid-operation reset drops Q and a pending rco pulse
    reset4();
    for (int i = 1; i <= 6; i++) apply4(2'b00, 1'b1, 1'b1, 0, i, 1'b0, 1'b0, "cnt");
    apply4(2'b11, 1'b1, 1'b1, 7, 7, 1'b1, 1'b0, "load7");
    #2 rst4 = 1'b1;
    #1 chk("midrst.Q", int'(q4), 0);
    chk("midrst.rco", int'(rco4), 0);
    en4 = 1'b0;
    @(negedge clk) rst4 = 1'b0;
    @(posedge clk); #1;
    apply4(2'b00, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0, "after_rst");

    // randomized ops on the 4-bit instance
    m4 = 1;
    for (int i = 0; i < 300; i++) begin
      m   = 2'($urandom_range(0, 3));
      en  = ($urandom_range(0, 7) != 0);
      cin = ($urandom_range(0, 5) != 0);
      eq  = model(4, 3, m4, m, en, cin, int'($urandom_range(0, 15)), er, et);
      apply4(m, en, cin, (m == 2'b11) ? eq : 0, eq, er, et, "rnd4");
      m4 = eq;
    end

    // generality: WIDTH=8, STEP=100
    apply8(2'b11, 1'b1, 1'b1, 50, 50, 1'b1, 1'b0, "w8.load50");
    apply8(2'b10, 1'b1, 1'b1, 0, 206, 1'b1, 1'b1, "w8.step");
    apply8(2'b11, 1'b1, 1'b1, 255, 255, 1'b1, 1'b0, "w8.load255");
    apply8(2'b00, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, "w8.up");
    m8 = 0;
    for (int i = 0; i < 200; i++) begin
      m   = 2'($urandom_range(0, 3));
      en  = ($urandom_range(0, 7) != 0);
      cin = ($urandom_range(0, 5) != 0);
      eq  = model(8, 100, m8, m, en, cin, int'($urandom_range(0, 255)), er, et);
      apply8(m, en, cin, (m == 2'b11) ? eq : 0, eq, er, et, "rnd8");
      m8 = eq;
    end

    // cascade: 300 up edges from 0
    pulses = 0; pulse_edge = 0;
    modoc = 2'b00; enc = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (hi_rco) begin
        pulses++;
        pulse_edge = i;
      end
    end
    enc = 1'b0;
    chk("cascade.Q", int'({hi_q, lo_q}), 44);
    chk("cascade.hi_rco_pulses", pulses, 1);
    chk("cascade.hi_rco_edge", pulse_edge, 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
# param_updown_counter

Parametrised synchronous up/down counter with load, step-down mode, registered ripple-carry-out (`rco`) and a cascade enable (`cin`/`tc`). It generalises the 4-bit counter checked by the tarea4 scoreboard to any width and any down-step. Several instances can be chained into wider counters. It sits as the DUT in the counter test benches and as a reusable counter primitive in later assignments.

## Interface
- `WIDTH`, default 4: counter width in bits; must be at least 2.
- `STEP`, default 3: decrement applied in mode 2'b10; legal range 1 ≤ STEP ≤ 2^WIDTH−1.
- `clk`  input  1  clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `enable`  input  1  block enable; when low, all state holds.
- `cin`  input  1  cascade count enable; gates modes 00/01/10 only; tie to 1 when unchained.
- `modo`  input  2  operation select: 00 = +1, 01 = −1, 10 = −STEP, 11 = load `D`.
- `D`  input  WIDTH  parallel load value.
- `Q`  output  WIDTH  registered count.
- `rco`  output  1  registered one-cycle pulse on wrap or load.
- `tc`  output  1  combinational terminal-count lookahead for cascading.

## Operation
- Reset (async, any time, including mid-operation):
  - `Q` = 0 and `rco` = 0 immediately, without waiting for an edge.
  - Counting resumes on the first rising edge after `reset` deasserts.
- Priority at each rising edge of `clk`: `reset` > (`enable` = 0: hold) > `modo`.
- Holds keep `Q` and force `rco` to 0 (see `rco` below).
- Counting is active in modes 00/01/10 only when `enable` = 1 and `cin` = 1.
  - If `cin` = 0 in those modes, `Q` holds.
- Mode 00: `Q` ← `Q`+1 mod 2^WIDTH. A wrap occurs when `Q` = 2^WIDTH−1 (becomes 0).
- Mode 01: `Q` ← `Q`−1 mod 2^WIDTH. A wrap occurs when `Q` = 0 (becomes 2^WIDTH−1).
- Mode 10: `Q` ← `Q`−STEP mod 2^WIDTH.
  - A wrap occurs when `Q` < STEP.
  - Example, WIDTH=4, STEP=3: 2→15, 1→14, 0→13.
- Mode 11: `Q` ← `D` whenever `enable` = 1; `cin` is ignored. Every load counts as an `rco` event.
- Arithmetic: compute at WIDTH+1 bits and truncate to WIDTH.
  - The wrap condition is the borrow or carry bit.
  - No saturation anywhere.
- `rco`: registered.
  - 1 for exactly the cycle following an edge that performed a wrap or a load.
  - 0 after every other edge, including hold edges.
  - Back-to-back wraps (e.g. repeated loads) keep `rco` high on consecutive cycles.
- `tc` (combinational): `enable` & `cin` & (next counting edge would wrap in the current `modo`).
  - `tc` = 0 in mode 11.
  - For cascading, drive the next stage's `cin` from this stage's `tc`.

## Timing
- Latency: `Q` and `rco` reflect an operation one `clk` edge after the inputs are sampled.
- `tc` is valid in the same cycle as its inputs.
- `D`, `modo`, `enable` and `cin` must be stable around the rising edge. No handshake.
- A reset assertion between edges clears outputs within the same cycle. A pending `rco` pulse is lost.
- A `modo` change takes effect on the very next edge; no pipeline drain.

## Test plan
- Up wrap, WIDTH=4:
  - Stimulus: reset, then `modo`=00, `enable`=1, `cin`=1 for 17 edges.
  - Required: `Q` goes 1..15, 0, 1.
  - Required: `rco`=1 only in the cycle after `Q` becomes 0.
  - Required: `tc`=1 while `Q`=15.
- Down-by-STEP wrap, WIDTH=4, STEP=3:
  - Stimulus: load 2 (`modo`=11, `D`=2), then `modo`=10 for 6 edges.
  - Required: `Q` goes 15, 12, 9, 6, 3, 0.
  - Required: `rco` pulses after the load and after 2→15 only.
  - Stimulus: load 1, one `modo`=10 edge. Required: `Q`=14.
  - Stimulus: load 0, one `modo`=10 edge. Required: `Q`=13.
- Hold conditions:
  - Stimulus: `Q`=9, `enable`=0 with `modo`=00 for 3 edges. Required: `Q`=9, `rco`=0.
  - Stimulus: `enable`=1, `cin`=0, `modo`=01. Required: `Q`=9.
  - Stimulus: `enable`=1, `cin`=0, `modo`=11 with `D`=5. Required: `Q`=5, `rco` pulses.
- Mid-operation reset:
  - Stimulus: count up to 7, then assert `reset` between edges.
  - Required: `Q`=0 and `rco`=0 before the next edge.
  - Required: after release, the first edge in mode 00 gives `Q`=1.
- Cascade, two WIDTH=4 instances (low `tc` → high `cin`):
  - Stimulus: count up 300 edges from 0.
  - Required: concatenated `Q` = 300 mod 256 = 44.
  - Required: the high stage's `rco` pulsed once, after the 255→0 edge.
- Width and step generality, WIDTH=8, STEP=100:
  - Stimulus: load 50, then one `modo`=10 edge. Required: `Q`=206, `rco`=1.
  - Stimulus: load 255, then one `modo`=00 edge. Required: `Q`=0, `rco`=1.
